uparc_muldiv_ctrl: RTL and testbench

- Sequencer for the integer multiply/divide unit: owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and registers the operands.
- Issues a one-cycle start to the multiplier or divider, waits for its ready, then writes the result into HI/LO.
- Raises a stall for MFHI/MFLO reads while an operation is in flight. Sits in the execute stage between the pipeline and the multiplier/divider datapaths.

---
 rtl/uparc_muldiv_ctrl_pkg.sv | 38 +++
 rtl/uparc_muldiv_ctrl.sv | 123 ++++++++++++
 tb/tb_uparc_muldiv_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uparc_muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// uparc_muldiv_ctrl_pkg : shared widths, op encodings and FSM states for the
// multiply/divide sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef UPARC_REG_WIDTH
`define UPARC_REG_WIDTH 32
`endif

package uparc_muldiv_ctrl_pkg;

  localparam int REG_WIDTH = `UPARC_REG_WIDTH;

  localparam logic [2:0] UPARC_MD_MULT  = 3'd0;
  localparam logic [2:0] UPARC_MD_MULTU = 3'd1;
  localparam logic [2:0] UPARC_MD_DIV   = 3'd2;
  localparam logic [2:0] UPARC_MD_DIVU  = 3'd3;
  localparam logic [2:0] UPARC_MD_MTHI  = 3'd4;
  localparam logic [2:0] UPARC_MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] code);
    return (code == UPARC_MD_DIV) || (code == UPARC_MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] code);
    return (code == UPARC_MD_MULT) || (code == UPARC_MD_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uparc_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// uparc_muldiv_ctrl : HI/LO owner and start/wait sequencer for the mul/div
// datapaths.  Optional: UPARC_MULDIV_DIVZERO_SKIP_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uparc_muldiv_ctrl
  import uparc_muldiv_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 op_valid,
  input  logic [2:0]           op_code,
  input  logic [REG_WIDTH-1:0] op_rs,
  input  logic [REG_WIDTH-1:0] op_rt,
  output logic                 op_ready,
  input  logic                 rd_req,
  input  logic                 rd_sel,
  output logic [REG_WIDTH-1:0] rd_data,
  output logic                 rd_stall,
  output logic                 busy,
  output logic                 mul_start,
  output logic                 mul_signd,
  output logic [REG_WIDTH-1:0] mul_a,
  output logic [REG_WIDTH-1:0] mul_b,
  input  logic                 mul_ready,
  input  logic [2*REG_WIDTH-1:0] mul_product,
  output logic                 div_start,
  output logic                 div_signd,
  output logic [REG_WIDTH-1:0] div_dividend,
  output logic [REG_WIDTH-1:0] div_divisor,
  input  logic                 div_ready,
  input  logic [REG_WIDTH-1:0] div_quotient,
  input  logic [REG_WIDTH-1:0] div_remainder,
  output logic [REG_WIDTH-1:0] hi,
  output logic [REG_WIDTH-1:0] lo
);

  md_state_t            state;
  logic [REG_WIDTH-1:0] opa;
  logic [REG_WIDTH-1:0] opb;
  logic                 unit_div;
  logic                 signd;
  logic                 div_zero_skip;
  logic                 sel_mul;
  logic                 sel_div;

`ifdef UPARC_MULDIV_DIVZERO_SKIP_EN
  assign div_zero_skip = md_is_div(op_code) && (op_rt == '0);
`else
  assign div_zero_skip = 1'b0;
`endif

  // nrst gating keeps op_ready low while reset is held even with op_valid up
  assign op_ready = nrst && (state == ST_IDLE) && op_valid && (op_code <= UPARC_MD_MTLO);
  assign busy     = (state != ST_IDLE);
  assign rd_data  = rd_sel ? hi : lo;
  assign rd_stall = rd_req && busy;

  assign sel_mul = busy && !unit_div;
  assign sel_div = busy && unit_div;

  assign mul_start    = sel_mul && (state == ST_START);
  assign mul_signd    = sel_mul && signd;
  assign mul_a        = sel_mul ? opa : '0;
  assign mul_b        = sel_mul ? opb : '0;
  assign div_start    = sel_div && (state == ST_START);
  assign div_signd    = sel_div && signd;
  assign div_dividend = sel_div ? opa : '0;
  assign div_divisor  = sel_div ? opb : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      opa      <= '0;
      opb      <= '0;
      unit_div <= 1'b0;
      signd    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_ready) begin
            if (op_code == UPARC_MD_MTHI) begin
              hi <= op_rs;
            end else if (op_code == UPARC_MD_MTLO) begin
              lo <= op_rs;
            end else if (div_zero_skip) begin
              hi <= op_rs;
              lo <= '1;
            end else begin
              opa      <= op_rs;
              opb      <= op_rt;
              unit_div <= md_is_div(op_code);
              signd    <= md_is_signed(op_code);
              state    <= ST_START;
            end
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!unit_div && mul_ready) begin
            {hi, lo} <= mul_product;
            state    <= ST_IDLE;
          end else if (unit_div && div_ready) begin
            hi    <= div_remainder;
            lo    <= div_quotient;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uparc_muldiv_ctrl.sv
// Directed bench for uparc_muldiv_ctrl with a zero-latency multiplier model
// and a divider model that raises ready ten cycles after start.
`default_nettype none

module tb_uparc_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_rs;
  logic [31:0] op_rt;
  logic        op_ready;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_stall;
  logic        busy;
  logic        mul_start;
  logic        mul_signd;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_ready;
  logic [63:0] mul_product;
  logic        div_start;
  logic        div_signd;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_ready;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int div_cnt = 0;
  int n_div_start = 0;
  int div_start_base;
  logic div_ready_force = 1'b0;

  always #5 clk = ~clk;

  uparc_muldiv_ctrl dut (
    .clk(clk), .nrst(nrst),
    .op_valid(op_valid), .op_code(op_code), .op_rs(op_rs), .op_rt(op_rt),
    .op_ready(op_ready),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_stall(rd_stall),
    .busy(busy),
    .mul_start(mul_start), .mul_signd(mul_signd), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product),
    .div_start(div_start), .div_signd(div_signd),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .hi(hi), .lo(lo)
  );

  // Fast multiplier: always ready, product is purely combinational.
  logic signed [63:0] ext_a;
  logic signed [63:0] ext_b;
  assign mul_ready   = 1'b1;
  assign ext_a       = {{32{mul_signd & mul_a[31]}}, mul_a};
  assign ext_b       = {{32{mul_signd & mul_b[31]}}, mul_b};
  assign mul_product = ext_a * ext_b;

  // Unsigned divider model; divide-by-zero returns all ones / dividend.
  assign div_quotient  = (div_divisor == 32'd0) ? 32'hFFFFFFFF : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == 32'd0) ? div_dividend : div_dividend % div_divisor;
  assign div_ready     = (div_cnt == 1) || div_ready_force;

  always @(posedge clk) begin
    if (div_start) begin
      div_cnt     <= 10;
      n_div_start <= n_div_start + 1;
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst     = 1'b0;
    op_valid = 1'b1;
    op_code  = 3'd4;
    op_rs    = 32'hDEADBEEF;
    op_rt    = 32'd0;
    rd_req   = 1'b0;
    rd_sel   = 1'b0;
    tick();
    tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_div_start", div_start, 0);
    nrst     = 1'b1;
    op_valid = 1'b0;
    tick();

    // MULT -3 * 7
    op_valid = 1'b1; op_code = 3'd0; op_rs = 32'hFFFFFFFD; op_rt = 32'd7;
    #1;
    chk("mult_T_op_ready", op_ready, 1);
    chk("mult_T_mul_start", mul_start, 0);
    tick();
    op_valid = 1'b0;
    #1;
    chk("mult_T1_mul_start", mul_start, 1);
    chk("mult_T1_mul_signd", mul_signd, 1);
    chk("mult_T1_mul_a", mul_a, 64'hFFFFFFFD);
    chk("mult_T1_div_start", div_start, 0);
    tick();
    chk("mult_T2_mul_start", mul_start, 0);
    chk("mult_T2_busy", busy, 1);
    tick();
    chk("mult_T3_hi", hi, 64'hFFFFFFFF);
    chk("mult_T3_lo", lo, 64'hFFFFFFEB);
    chk("mult_T3_busy", busy, 0);

    // MULTU then MTLO held from T+1
    op_valid = 1'b1; op_code = 3'd1; op_rs = 32'hFFFFFFFF; op_rt = 32'd2;
    #1;
    chk("multu_T_op_ready", op_ready, 1);
    tick();
    op_code = 3'd5; op_rs = 32'h12345678; op_rt = 32'd0;
    #1;
    chk("multu_T1_op_ready", op_ready, 0);
    chk("multu_T1_mul_start", mul_start, 1);
    chk("multu_T1_mul_signd", mul_signd, 0);
    tick();
    chk("multu_T2_op_ready", op_ready, 0);
    tick();
    chk("multu_T3_hi", hi, 64'h00000001);
    chk("multu_T3_lo", lo, 64'hFFFFFFFE);
    chk("mtlo_T3_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    #1;
    chk("mtlo_T4_lo", lo, 64'h12345678);
    chk("mtlo_T4_hi", hi, 64'h00000001);
    chk("mtlo_T4_busy", busy, 0);

    // MTHI
    op_valid = 1'b1; op_code = 3'd4; op_rs = 32'hA5A5A5A5;
    #1;
    chk("mthi_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    #1;
    chk("mthi_hi", hi, 64'hA5A5A5A5);
    chk("mthi_busy", busy, 0);

    // Illegal code 6 is ignored
    op_valid = 1'b1; op_code = 3'd6; op_rs = 32'h11111111;
    #1;
    chk("code6_op_ready", op_ready, 0);
    tick();
    op_valid = 1'b0;
    #1;
    chk("code6_busy", busy, 0);
    chk("code6_hi", hi, 64'hA5A5A5A5);

    // DIVU 100 / 7 with slow divider and a stalled MFHI
    op_valid = 1'b1; op_code = 3'd3; op_rs = 32'd100; op_rt = 32'd7;
    #1;
    chk("divu_T_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    rd_req = 1'b1; rd_sel = 1'b1;
    #1;
    chk("divu_T1_div_start", div_start, 1);
    chk("divu_T1_div_signd", div_signd, 0);
    chk("divu_T1_dividend", div_dividend, 100);
    chk("divu_T1_divisor", div_divisor, 7);
    chk("divu_T1_mul_a", mul_a, 0);
    chk("divu_T1_rd_stall", rd_stall, 1);
    for (int i = 2; i <= 11; i++) begin
      tick();
      chk("divu_wait_busy", busy, 1);
      chk("divu_wait_rd_stall", rd_stall, 1);
      chk("divu_wait_div_start", div_start, 0);
    end
    tick();
    chk("divu_done_busy", busy, 0);
    chk("divu_done_lo", lo, 14);
    chk("divu_done_hi", hi, 2);
    chk("divu_done_rd_stall", rd_stall, 0);
    chk("divu_done_rd_data", rd_data, 2);
    rd_sel = 1'b0;
    #1;
    chk("divu_done_rd_lo", rd_data, 14);
    rd_req = 1'b0;

    // DIV by zero
    div_start_base = n_div_start;
    op_valid = 1'b1; op_code = 3'd2; op_rs = 32'd55; op_rt = 32'd0;
    #1;
    chk("div0_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    #1;
`ifdef UPARC_MULDIV_DIVZERO_SKIP_EN
    chk("div0_T1_busy", busy, 0);
    chk("div0_T1_div_start", div_start, 0);
    chk("div0_T1_hi", hi, 55);
    chk("div0_T1_lo", lo, 64'hFFFFFFFF);
`else
    chk("div0_T1_busy", busy, 1);
    chk("div0_T1_div_start", div_start, 1);
    chk("div0_T1_div_signd", div_signd, 1);
`endif
    for (int i = 2; i <= 12; i++) tick();
    chk("div0_busy", busy, 0);
    chk("div0_hi", hi, 55);
    chk("div0_lo", lo, 64'hFFFFFFFF);
`ifdef UPARC_MULDIV_DIVZERO_SKIP_EN
    chk("div0_start_count", n_div_start - div_start_base, 0);
`else
    chk("div0_start_count", n_div_start - div_start_base, 1);
`endif

    // Reset during WAIT of a DIV, then late ready pulses
    op_valid = 1'b1; op_code = 3'd2; op_rs = 32'd50; op_rt = 32'd5;
    tick();
    op_valid = 1'b0;
    tick();
    chk("rstwait_busy", busy, 1);
    nrst = 1'b0;
    #1;
    chk("rstwait_busy_low", busy, 0);
    chk("rstwait_hi", hi, 0);
    chk("rstwait_lo", lo, 0);
    tick();
    nrst = 1'b1;
    div_ready_force = 1'b1;
    tick();
    div_ready_force = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("late_ready_hi", hi, 0);
    chk("late_ready_lo", lo, 0);
    chk("late_ready_busy", busy, 0);
    chk("late_ready_div_start", div_start, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
